// File: rtl/seq_divider_pkg.sv
// Shared types and sizing helpers for the seq_divider restoring divider.
// Optional signed arithmetic is selected with the SEQ_DIVIDER_SIGNED_EN macro.
package seq_divider_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   localparam int unsigned DEF_DIVIDEND_W = 8;
   localparam int unsigned DEF_DIVISOR_W  = 7;

   // Step counter must hold the value DIVIDEND_W itself.
   function automatic int unsigned cnt_width(input int unsigned dividend_w);
      return $clog2(dividend_w + 1);
   endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// compare against the divisor and conditionally subtract.
module seq_divider_step #(
   parameter int unsigned DIVISOR_W = 7
) (
   input  logic [DIVISOR_W:0]   rem_i,
   input  logic                 bit_i,
   input  logic [DIVISOR_W-1:0] divisor_i,
   output logic [DIVISOR_W:0]   rem_o,
   output logic                 qbit_o
);

   logic [DIVISOR_W:0] shifted;

   always_comb begin
      shifted = {rem_i[DIVISOR_W-1:0], bit_i};
      // rem_i MSB is zero in normal operation; folding it in keeps the step exact if it were set.
      qbit_o  = rem_i[DIVISOR_W] | (shifted >= {1'b0, divisor_i});
      rem_o   = qbit_o ? (shifted - {1'b0, divisor_i}) : shifted;
   end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with start/busy/valid handshake and divide-by-zero flag.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands and results.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int unsigned DIVIDEND_W = DEF_DIVIDEND_W,
   parameter int unsigned DIVISOR_W  = DEF_DIVISOR_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividendin,
   input  logic [DIVISOR_W-1:0]  divisorin,
   output logic                  busy,
   output logic                  valid,
   output logic                  divzero,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder
);

   localparam int unsigned CW = cnt_width(DIVIDEND_W);

   state_e                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [DIVIDEND_W-1:0]   dvd_q, dvd_d;
   logic [DIVISOR_W:0]      rem_q, rem_d;
   logic [DIVISOR_W-1:0]    dvs_q, dvs_d;
   logic                    zero_q, zero_d;
   logic                    busy_q, busy_d;
   logic                    valid_q, valid_d;
   logic                    divzero_q, divzero_d;
   logic [DIVIDEND_W-1:0]   quotient_q, quotient_d;
   logic [DIVISOR_W-1:0]    remainder_q, remainder_d;

   logic [DIVIDEND_W-1:0]   dvd_cap;
   logic [DIVISOR_W-1:0]    dvs_cap;
   logic [DIVIDEND_W-1:0]   quo_res;
   logic [DIVISOR_W-1:0]    rem_res;
   logic [DIVISOR_W:0]      step_rem;
   logic                    step_qbit;

   seq_divider_step #(
      .DIVISOR_W (DIVISOR_W)
   ) u_step (
      .rem_i     (rem_q),
      .bit_i     (dvd_q[DIVIDEND_W-1]),
      .divisor_i (dvs_q),
      .rem_o     (step_rem),
      .qbit_o    (step_qbit)
   );

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic neg_quo_q, neg_quo_d;
   logic neg_rem_q, neg_rem_d;

   // The core divides magnitudes; signs are reapplied on the DONE write.
   always_comb begin
      dvd_cap   = dividendin[DIVIDEND_W-1] ? -dividendin : dividendin;
      dvs_cap   = divisorin[DIVISOR_W-1]   ? -divisorin  : divisorin;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      if (start && !busy_q) begin
         neg_quo_d = dividendin[DIVIDEND_W-1] ^ divisorin[DIVISOR_W-1];
         neg_rem_d = dividendin[DIVIDEND_W-1];
      end
      quo_res = neg_quo_q ? -dvd_q : dvd_q;
      rem_res = neg_rem_q ? -rem_q[DIVISOR_W-1:0] : rem_q[DIVISOR_W-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end
`else
   always_comb begin
      dvd_cap = dividendin;
      dvs_cap = divisorin;
      quo_res = dvd_q;
      rem_res = rem_q[DIVISOR_W-1:0];
   end
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dvd_d       = dvd_q;
      rem_d       = rem_q;
      dvs_d       = dvs_q;
      zero_d      = zero_q;
      busy_d      = busy_q;
      valid_d     = valid_q;
      divzero_d   = divzero_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               dvd_d     = dvd_cap;
               dvs_d     = dvs_cap;
               rem_d     = '0;
               cnt_d     = CW'(DIVIDEND_W);
               zero_d    = (divisorin == '0);
               valid_d   = 1'b0;
               divzero_d = 1'b0;
               busy_d    = 1'b1;
               state_d   = RUN;
            end
         end
         RUN: begin
            if (cnt_q != '0) begin
               // Dividend bits leave at the MSB while quotient bits enter at the LSB.
               rem_d = step_rem;
               dvd_d = {dvd_q[DIVIDEND_W-2:0], step_qbit};
               cnt_d = cnt_q - CW'(1);
            end else begin
               state_d   = DONE;
               busy_d    = 1'b0;
               valid_d   = 1'b1;
               divzero_d = zero_q;
               if (zero_q) begin
                  quotient_d  = '1;
                  remainder_d = '0;
               end else begin
                  quotient_d  = quo_res;
                  remainder_d = rem_res;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         dvd_q       <= '0;
         rem_q       <= '0;
         dvs_q       <= '0;
         zero_q      <= 1'b0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         divzero_q   <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dvd_q       <= dvd_d;
         rem_q       <= rem_d;
         dvs_q       <= dvs_d;
         zero_q      <= zero_d;
         busy_q      <= busy_d;
         valid_q     <= valid_d;
         divzero_q   <= divzero_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   assign busy      = busy_q;
   assign valid     = valid_q;
   assign divzero   = divzero_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands
// against an arithmetic reference (signed when SEQ_DIVIDER_SIGNED_EN is defined).
module tb_seq_divider;

   localparam int unsigned DW = 8;
   localparam int unsigned VW = 7;

   logic          clk;
   logic          reset;
   logic          start;
   logic [DW-1:0] dividendin;
   logic [VW-1:0] divisorin;
   logic          busy;
   logic          valid;
   logic          divzero;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;

   int total = 0;
   int bad   = 0;

   seq_divider #(
      .DIVIDEND_W (DW),
      .DIVISOR_W  (VW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .dividendin (dividendin),
      .divisorin  (divisorin),
      .busy       (busy),
      .valid      (valid),
      .divzero    (divzero),
      .quotient   (quotient),
      .remainder  (remainder)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                        output logic [DW-1:0] q, output logic [VW-1:0] r, output logic dz);
      int qi, ri;
      if (b == '0) begin
         q = '1; r = '0; dz = 1'b1;
      end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
         qi = int'($signed(a)) / int'($signed(b));
         ri = int'($signed(a)) % int'($signed(b));
`else
         qi = int'(a) / int'(b);
         ri = int'(a) % int'(b);
`endif
         q = qi[DW-1:0]; r = ri[VW-1:0]; dz = 1'b0;
      end
   endtask

   task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b);
      dividendin = a;
      divisorin  = b;
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
   endtask

   task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b,
                         input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic edz);
      issue(a, b);
      chk("acc_busy", 32'(busy), 32'd1);
      chk("acc_valid", 32'(valid), 32'd0);
      for (int k = 1; k <= int'(DW) + 1; k++) begin
         @(posedge clk); #1;
         if (k <= int'(DW)) begin
            chk("lat_valid", 32'(valid), 32'd0);
            chk("lat_busy", 32'(busy), 32'd1);
         end
      end
      chk("done_valid", 32'(valid), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("quotient", 32'(quotient), 32'(eq));
      chk("remainder", 32'(remainder), 32'(er));
      chk("divzero", 32'(divzero), 32'(edz));
   endtask

   initial begin
      logic [DW-1:0] a, eq;
      logic [VW-1:0] b, er;
      logic          edz;

      reset = 1'b0; start = 1'b0; dividendin = '0; divisorin = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_divzero", 32'(divzero), 32'd0);
      chk("rst_quotient", 32'(quotient), 32'd0);
      chk("rst_remainder", 32'(remainder), 32'd0);
      #3 reset = 1'b1;

`ifdef SEQ_DIVIDER_SIGNED_EN
      run_op(8'h9C, 7'h07, 8'hF2, 7'h7E, 1'b0);
      run_op(8'h80, 7'h7F, 8'h80, 7'h00, 1'b0);
      run_op(8'd55, 7'd0, 8'hFF, 7'h00, 1'b1);
`else
      run_op(8'd200, 7'd7, 8'd28, 7'd4, 1'b0);
      run_op(8'd255, 7'd1, 8'd255, 7'd0, 1'b0);
      run_op(8'd255, 7'd127, 8'd2, 7'd1, 1'b0);
      run_op(8'd0, 7'd5, 8'd0, 7'd0, 1'b0);
      run_op(8'd55, 7'd0, 8'd255, 7'd0, 1'b1);

      // A second start three edges into the run must be ignored.
      issue(8'd100, 7'd3);
      for (int k = 1; k <= int'(DW) + 1; k++) begin
         @(posedge clk); #1;
         if (k == 2) begin
            dividendin = 8'd9; divisorin = 7'd9; start = 1'b1;
         end
         if (k == 3) start = 1'b0;
      end
      chk("busy_ign_valid", 32'(valid), 32'd1);
      chk("busy_ign_quotient", 32'(quotient), 32'd33);
      chk("busy_ign_remainder", 32'(remainder), 32'd1);
      // Back-to-back start on the edge after valid.
      run_op(8'd17, 7'd4, 8'd4, 7'd1, 1'b0);
`endif

      // Reset during RUN step 4 clears everything asynchronously.
      issue(8'd77, 7'd6);
      repeat (4) begin @(posedge clk); #1; end
      reset = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_valid", 32'(valid), 32'd0);
      chk("mid_rst_divzero", 32'(divzero), 32'd0);
      chk("mid_rst_quotient", 32'(quotient), 32'd0);
      chk("mid_rst_remainder", 32'(remainder), 32'd0);
      #3 reset = 1'b1;
      model(8'd17, 7'd5, eq, er, edz);
      run_op(8'd17, 7'd5, eq, er, edz);

      for (int n = 0; n < 40; n++) begin
         a = DW'($urandom);
         b = ($urandom_range(0, 7) == 0) ? '0 : VW'($urandom);
         if (n == 0) begin a = 8'h80; b = '1; end
         model(a, b, eq, er, edz);
         run_op(a, b, eq, er, edz);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
